// File: rtl/shield_scheduler.sv
// Purpose: shield power-up lifecycle (spawn delay, pickup window, timed protection, cooldown) with round-robin slots.
// Latency: all outputs registered; a cycle's inputs are reflected one clk edge later.
// Backpressure: none; game_en=0 freezes all state and suppresses pulses, restart overrides everything.
module shield_scheduler #(
    parameter int SPAWN_DELAY     = 300,
    parameter int SHIELD_DURATION = 600,
    parameter int COOLDOWN        = 180,
    parameter int MAX_ABSORB      = 1,
    parameter int NUM_SLOTS       = 4,
    parameter int CNT_W           = 12,
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int HL_W   = $clog2(MAX_ABSORB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_en,
    input  logic              frame_tick,
    input  logic              restart,
    input  logic              pickup,
    input  logic [9:0]        hit,
    output logic              shield_visible,
    output logic [SLOT_W-1:0] shield_slot,
    output logic              is_shielded,
    output logic [HL_W-1:0]   hits_left,
    output logic              hit_absorbed,
    output logic              damage
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPAWN,
        AVAILABLE,
        ACTIVE,
        COOLDOWN_ST
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;

    logic              hit_any;
    logic              tick_done;
    logic              absorb;
    logic [HL_W-1:0]   hits_rem;
    logic [SLOT_W-1:0] slot_next;

    assign hit_any   = |hit;
    // A zero counter is treated like 1 so a stray 0 still leaves on the next tick.
    assign tick_done = frame_tick && (counter <= CNT_W'(1));
    assign absorb    = hit_any && (hits_left != '0);
    assign hits_rem  = absorb ? (hits_left - HL_W'(1)) : hits_left;
    assign slot_next = (shield_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : shield_slot + SLOT_W'(1);

    // Lifecycle FSM: state, frame counter, slot, absorb budget and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            counter        <= '0;
            shield_slot    <= '0;
            hits_left      <= '0;
            shield_visible <= 1'b0;
            is_shielded    <= 1'b0;
            hit_absorbed   <= 1'b0;
            damage         <= 1'b0;
        end else begin
            hit_absorbed <= 1'b0;
            damage       <= 1'b0;
            if (restart) begin
                // Restart beats every other input, including a frozen game.
                state          <= WAIT_SPAWN;
                counter        <= CNT_W'(SPAWN_DELAY);
                hits_left      <= '0;
                shield_visible <= 1'b0;
                is_shielded    <= 1'b0;
            end else if (game_en) begin
                case (state)
                    IDLE: begin
                        damage  <= hit_any;
                        state   <= WAIT_SPAWN;
                        counter <= CNT_W'(SPAWN_DELAY);
                    end
                    WAIT_SPAWN: begin
                        damage <= hit_any;
                        if (frame_tick) begin
                            if (counter != '0) counter <= counter - CNT_W'(1);
                            if (tick_done) begin
                                state          <= AVAILABLE;
                                shield_visible <= 1'b1;
                                shield_slot    <= slot_next;
                            end
                        end
                    end
                    AVAILABLE: begin
                        // A hit in the pickup cycle lands before protection exists.
                        damage <= hit_any;
                        if (pickup) begin
                            state          <= ACTIVE;
                            shield_visible <= 1'b0;
                            is_shielded    <= 1'b1;
                            counter        <= CNT_W'(SHIELD_DURATION);
                            hits_left      <= HL_W'(MAX_ABSORB);
                        end
                    end
                    ACTIVE: begin
                        hit_absorbed <= absorb;
                        damage       <= hit_any && !absorb;
                        if (hits_rem == '0 || tick_done) begin
                            state       <= COOLDOWN_ST;
                            is_shielded <= 1'b0;
                            hits_left   <= '0;
                            counter     <= CNT_W'(COOLDOWN);
                        end else begin
                            hits_left <= hits_rem;
                            if (frame_tick) counter <= counter - CNT_W'(1);
                        end
                    end
                    COOLDOWN_ST: begin
                        damage <= hit_any;
                        if (tick_done) begin
                            state   <= WAIT_SPAWN;
                            counter <= CNT_W'(SPAWN_DELAY);
                        end else if (frame_tick) begin
                            counter <= counter - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shield_scheduler.sv
// Testbench for shield_scheduler: directed lifecycle steps plus randomized traffic.
// Expected outputs come from a phase/elapsed-ticks model of the shield lifecycle.
// Every cycle is compared against the model; key moments also against constants.
module tb_shield_scheduler;

    localparam int SPAWN = 300;
    localparam int DUR   = 600;
    localparam int COOL  = 180;
    localparam int MAXA  = 1;
    localparam int NSLOT = 4;

    logic       clk;
    logic       rst;
    logic       game_en;
    logic       frame_tick;
    logic       restart;
    logic       pickup;
    logic [9:0] hit;
    logic       shield_visible;
    logic [1:0] shield_slot;
    logic       is_shielded;
    logic [0:0] hits_left;
    logic       hit_absorbed;
    logic       damage;

    int tests = 0;
    int fails = 0;

    // Reference model: lifecycle phase and frames elapsed inside it.
    typedef enum int {P_IDLE, P_WAIT, P_AVAIL, P_ACTIVE, P_COOL} phase_t;
    phase_t m_phase;
    int     m_elapsed;
    int     m_hl;
    int     m_slot;
    bit     m_abs;
    bit     m_dmg;

    shield_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .game_en        (game_en),
        .frame_tick     (frame_tick),
        .restart        (restart),
        .pickup         (pickup),
        .hit            (hit),
        .shield_visible (shield_visible),
        .shield_slot    (shield_slot),
        .is_shielded    (is_shielded),
        .hits_left      (hits_left),
        .hit_absorbed   (hit_absorbed),
        .damage         (damage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_hl = 0; m_slot = 0; m_abs = 0; m_dmg = 0;
    endtask

    task automatic model_step(input bit r, input bit en, input bit tk, input bit pk, input bit hany);
        m_abs = 0;
        m_dmg = 0;
        if (r) begin
            m_phase = P_WAIT; m_elapsed = 0; m_hl = 0;
        end else if (en) begin
            case (m_phase)
                P_IDLE: begin
                    m_dmg = hany; m_phase = P_WAIT; m_elapsed = 0;
                end
                P_WAIT: begin
                    m_dmg = hany;
                    if (tk) m_elapsed++;
                    if (m_elapsed >= SPAWN) begin
                        m_phase = P_AVAIL; m_slot = (m_slot + 1) % NSLOT;
                    end
                end
                P_AVAIL: begin
                    m_dmg = hany;
                    if (pk) begin
                        m_phase = P_ACTIVE; m_elapsed = 0; m_hl = MAXA;
                    end
                end
                P_ACTIVE: begin
                    if (hany && m_hl > 0) begin
                        m_abs = 1; m_hl--;
                    end else begin
                        m_dmg = hany;
                    end
                    if (tk) m_elapsed++;
                    if (m_hl == 0 || m_elapsed >= DUR) begin
                        m_phase = P_COOL; m_elapsed = 0; m_hl = 0;
                    end
                end
                default: begin
                    m_dmg = hany;
                    if (tk) m_elapsed++;
                    if (m_elapsed >= COOL) begin
                        m_phase = P_WAIT; m_elapsed = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic chk_model();
        chk("visible", 32'(shield_visible), 32'(m_phase == P_AVAIL));
        chk("shielded", 32'(is_shielded), 32'(m_phase == P_ACTIVE));
        chk("slot", 32'(shield_slot), 32'(m_slot));
        chk("hits_left", 32'(hits_left), 32'(m_hl));
        chk("absorbed", 32'(hit_absorbed), 32'(m_abs));
        chk("damage", 32'(damage), 32'(m_dmg));
    endtask

    function automatic logic [9:0] rand_hit(input int pct);
        logic [9:0] h;
        h = '0;
        if ($urandom_range(0, 99) < pct) h = 10'($urandom_range(1, 1023));
        return h;
    endfunction

    task automatic step(input bit r, input bit en, input bit tk, input bit pk, input logic [9:0] h);
        restart = r; game_en = en; frame_tick = tk; pickup = pk; hit = h;
        @(posedge clk);
        #1;
        model_step(r, en, tk, pk, |h);
        chk_model();
    endtask

    task automatic wait_visible(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (shield_visible) break;
            step(0, 1, 1'($urandom_range(0, 1)), 0, rand_hit(10));
        end
        chk("wait_visible", 32'(shield_visible), 32'd1);
    endtask

    initial begin
        bit pulse_seen;
        rst = 1'b1; game_en = 0; frame_tick = 0; restart = 0; pickup = 0; hit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_visible", 32'(shield_visible), 32'd0);
        chk("rst_slot", 32'(shield_slot), 32'd0);
        chk("rst_hits_left", 32'(hits_left), 32'd0);
        chk("rst_pulses", 32'({is_shielded, hit_absorbed, damage}), 32'd0);
        rst = 1'b0;

        // 1: first spawn after exactly SPAWN ticks, at slot 1
        step(0, 1, 0, 0, '0);
        for (int i = 0; i < SPAWN - 1; i++) step(0, 1, 1, 0, rand_hit(10));
        chk("t1_not_yet", 32'(shield_visible), 32'd0);
        step(0, 1, 1, 0, '0);
        chk("t1_visible", 32'(shield_visible), 32'd1);
        chk("t1_slot", 32'(shield_slot), 32'd1);

        // 2: pickup then a single hit is absorbed and depletes the shield
        step(0, 1, 0, 1, '0);
        chk("t2_shielded", 32'(is_shielded), 32'd1);
        chk("t2_hl_full", 32'(hits_left), 32'd1);
        step(0, 1, 0, 0, 10'h004);
        chk("t2_absorbed", 32'(hit_absorbed), 32'd1);
        chk("t2_no_damage", 32'(damage), 32'd0);
        chk("t2_hl_empty", 32'(hits_left), 32'd0);
        chk("t2_unshielded", 32'(is_shielded), 32'd0);
        step(0, 1, 0, 0, '0);
        chk("t2_pulse_gone", 32'(hit_absorbed), 32'd0);
        wait_visible(3000);
        chk("t2_slot", 32'(shield_slot), 32'd2);

        // 3: timed expiry after DUR ticks, then COOL+SPAWN ticks to the next spawn
        step(0, 1, 0, 1, '0);
        for (int i = 0; i < DUR - 1; i++) step(0, 1, 1, 0, '0);
        chk("t3_still_on", 32'(is_shielded), 32'd1);
        step(0, 1, 1, 0, '0);
        chk("t3_expired", 32'(is_shielded), 32'd0);
        for (int i = 0; i < COOL + SPAWN - 1; i++) step(0, 1, 1, 0, rand_hit(10));
        chk("t3_not_yet", 32'(shield_visible), 32'd0);
        step(0, 1, 1, 0, '0);
        chk("t3_visible", 32'(shield_visible), 32'd1);
        chk("t3_slot", 32'(shield_slot), 32'd3);

        // 4: pickup and hit together: damage passes, shield still taken at full strength
        step(0, 1, 0, 1, 10'h201);
        chk("t4_damage", 32'(damage), 32'd1);
        chk("t4_absorbed", 32'(hit_absorbed), 32'd0);
        chk("t4_shielded", 32'(is_shielded), 32'd1);
        chk("t4_hl", 32'(hits_left), 32'd1);

        // 5: freeze mid-ACTIVE; remaining ticks still due after resume
        for (int i = 0; i < 100; i++) step(0, 1, 1, 0, '0);
        pulse_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 1, 1'($urandom_range(0, 1)), rand_hit(50));
            if (hit_absorbed || damage || !is_shielded) pulse_seen = 1;
        end
        chk("t5_frozen_quiet", 32'(pulse_seen), 32'd0);
        for (int i = 0; i < DUR - 101; i++) step(0, 1, 1, 0, '0);
        chk("t5_still_on", 32'(is_shielded), 32'd1);
        step(0, 1, 1, 0, '0);
        chk("t5_expired", 32'(is_shielded), 32'd0);

        // 6: restart in ACTIVE reloads the spawn delay and keeps the slot
        wait_visible(3000);
        chk("t6_slot_wrap", 32'(shield_slot), 32'd0);
        step(0, 1, 0, 1, '0);
        for (int i = 0; i < 50; i++) step(0, 1, 1, 0, '0);
        step(1, 1, 1, 0, '0);
        chk("t6_restart_unshield", 32'(is_shielded), 32'd0);
        chk("t6_restart_hl", 32'(hits_left), 32'd0);
        for (int i = 0; i < SPAWN - 1; i++) step(0, 1, 1, 0, '0);
        chk("t6_reload_not_yet", 32'(shield_visible), 32'd0);
        step(0, 1, 1, 0, '0);
        chk("t6_reload_visible", 32'(shield_visible), 32'd1);
        chk("t6_slot", 32'(shield_slot), 32'd1);

        // async reset in COOLDOWN clears everything without a clock edge
        step(0, 1, 0, 1, '0);
        step(0, 1, 0, 0, 10'h3ff);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, '0);
        step(0, 1, 0, 0, 10'h010);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_damage", 32'(damage), 32'd0);
        chk("arst_slot", 32'(shield_slot), 32'd0);
        chk("arst_outputs", 32'({shield_visible, is_shielded, hits_left, hit_absorbed}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), rand_hit(15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
